// File: rtl/gba_fb_scanout.sv
// Framebuffer scan-out and video timing: reads the frame in raster order and
// drives RGB888 plus sync/blank flags, with the frame start locked to the writer.
//
// state   | meaning
// ST_WAIT | frame finished; blank lines until sync, freerun or timeout
// ST_RUN  | frame in progress, lines 0..V_MIN-1
module gba_fb_scanout #(
  parameter int H_ACTIVE = 240,
  parameter int H_TOTAL  = 256,
  parameter int HS_START = 244,
  parameter int HS_END   = 252,
  parameter int V_ACTIVE = 160,
  parameter int VS_START = 163,
  parameter int VS_END   = 166,
  parameter int V_MIN    = 228,
  parameter int V_MAX    = 300,
  parameter int CE_DIV   = 4,
  parameter int RD_LAT   = 1,
  parameter int CBITS    = 5,
  parameter int AW       = 16
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               freerun,
  input  logic               fb_frame_done,
  output logic [AW-1:0]      fb_addr,
  input  logic [3*CBITS-1:0] fb_q,
  output logic               ce_pix,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               hs,
  output logic               vs,
  output logic               hbl,
  output logic               vbl,
  output logic               de,
  output logic               sync_missed,
  output logic               locked
);

  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_MAX);
  localparam int DW      = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int FB_LAST = H_ACTIVE * V_ACTIVE - 1;

  typedef enum logic {ST_WAIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state;
  logic [DW-1:0]       div;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic                pend;
  logic [RD_LAT-1:0]   rd_sr;
  logic [3*CBITS-1:0]  pix_q;
  logic                s_hbl, s_vbl, s_de, s_hs, s_vs;

  logic x_act, y_act, issue, line_end, frame_end;
  logic restart_sync, restart_to, restart;

  function automatic logic [7:0] expand(input logic [CBITS-1:0] c);
    return {c, c[CBITS-1 -: 8-CBITS]};
  endfunction

  assign x_act    = x < XW'(H_ACTIVE);
  assign y_act    = y < YW'(V_ACTIVE);
  assign issue    = ce_pix && x_act && y_act;
  assign line_end = ce_pix && (x == XW'(H_TOTAL-1));

  // The last RUN line is judged with the WAIT rules, so a pending sync yields
  // exactly V_MIN-line frames instead of one extra blank line.
  assign frame_end    = (state == ST_WAIT) || (y == YW'(V_MIN-1));
  assign restart_sync = line_end && frame_end && (freerun || pend);
  assign restart_to   = line_end && (state == ST_WAIT) && !(freerun || pend)
                        && (y == YW'(V_MAX-1));
  assign restart      = restart_sync || restart_to;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div         <= '0;
      ce_pix      <= 1'b0;
      x           <= '0;
      y           <= YW'(V_ACTIVE);
      state       <= ST_WAIT;
      pend        <= 1'b0;
      fb_addr     <= '0;
      rd_sr       <= '0;
      pix_q       <= '0;
      s_hbl       <= 1'b0;
      s_vbl       <= 1'b0;
      s_de        <= 1'b0;
      s_hs        <= 1'b0;
      s_vs        <= 1'b0;
      hbl         <= 1'b0;
      vbl         <= 1'b0;
      de          <= 1'b0;
      hs          <= 1'b0;
      vs          <= 1'b0;
      vga_r       <= 8'd0;
      vga_g       <= 8'd0;
      vga_b       <= 8'd0;
      sync_missed <= 1'b0;
      locked      <= 1'b0;
    end else begin
      div         <= (div == DW'(CE_DIV-1)) ? '0 : div + 1'b1;
      ce_pix      <= (div == '0);
      sync_missed <= 1'b0;
      rd_sr       <= RD_LAT'({rd_sr, issue});
      if (rd_sr[RD_LAT-1]) pix_q <= fb_q;
      // A pulse coinciding with the restart survives the clear.
      pend <= fb_frame_done || (pend && !restart);

      if (ce_pix) begin
        s_hbl <= !x_act;
        s_vbl <= !y_act;
        s_de  <= x_act && y_act;
        s_hs  <= (x >= XW'(HS_START)) && (x < XW'(HS_END));
        if (x == '0) s_vs <= (y >= YW'(VS_START)) && (y < YW'(VS_END));

        hbl   <= s_hbl;
        vbl   <= s_vbl;
        de    <= s_de;
        hs    <= s_hs;
        vs    <= s_vs;
        vga_r <= s_de ? expand(pix_q[3*CBITS-1 -: CBITS]) : 8'd0;
        vga_g <= s_de ? expand(pix_q[2*CBITS-1 -: CBITS]) : 8'd0;
        vga_b <= s_de ? expand(pix_q[CBITS-1:0])          : 8'd0;

        if (restart)
          fb_addr <= '0;
        else if (issue && (fb_addr != AW'(FB_LAST)))
          fb_addr <= fb_addr + 1'b1;

        if (line_end) begin
          x <= '0;
          if (restart) begin
            y           <= '0;
            state       <= ST_RUN;
            locked      <= restart_sync && !freerun;
            sync_missed <= restart_to;
          end else begin
            y <= y + 1'b1;
            if (frame_end) state <= ST_WAIT;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gba_fb_scanout.sv
// Directed bench for gba_fb_scanout on a shrunken raster (12x16 lines max) so
// whole frames fit in a short run; expectations are hand-derived step numbers.
module tb_gba_fb_scanout;

  localparam int HA = 8, HT = 12, HSS = 9, HSE = 11;
  localparam int VA = 6, VSS = 7, VSE = 9, VMN = 12, VMX = 16;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1, freerun = 1'b0, fb_frame_done = 1'b0;
  logic [15:0] fb_addr;
  logic [14:0] fb_q = '0;
  logic        ce_pix, hs, vs, hbl, vbl, de, sync_missed, locked;
  logic [7:0]  vga_r, vga_g, vga_b;

  int n_chk = 0, n_pass = 0;
  int steps, cyc, hs_cnt;
  bit mon_on = 0, pix_chk = 0, ce_prev, vbl_prev, de_prev;
  int vfall_q[$], smiss_q[$], derise_q[$], hs_at_de[$], rgb_at_de[$];
  int px, py;
  bit ppre;

  gba_fb_scanout #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
    .V_ACTIVE(VA), .VS_START(VSS), .VS_END(VSE), .V_MIN(VMN), .V_MAX(VMX),
    .CE_DIV(4), .RD_LAT(1), .CBITS(5), .AW(16)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .freerun(freerun), .fb_frame_done(fb_frame_done),
    .fb_addr(fb_addr), .fb_q(fb_q), .ce_pix(ce_pix),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hs(hs), .vs(vs), .hbl(hbl), .vbl(vbl), .de(de),
    .sync_missed(sync_missed), .locked(locked)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [14:0] word_of(input int a);
    return 15'((a * 1237 + 4660) & 32'h7fff);
  endfunction

  function automatic logic [23:0] rgb_of(input logic [14:0] w);
    logic [4:0] r, g, b;
    r = w[14:10]; g = w[9:5]; b = w[4:0];
    return {r, r[4:2], g, g[4:2], b, b[4:2]};
  endfunction

  // Single-cycle-latency framebuffer port B.
  always @(posedge clk_sys) fb_q <= word_of(int'(fb_addr));

  // Freerun raster: pixel step p -> position; first line is the post-reset blank line.
  function automatic void pos_of(input int p, output int x, output int y, output bit pre);
    int q;
    if (p < HT) begin
      x = p; y = VA; pre = 1'b1;
    end else begin
      q = p - HT; x = q % HT; y = (q / HT) % VMN; pre = 1'b0;
    end
  endfunction

  function automatic int exp_addr(input int p);
    int x, y, n;
    bit pre;
    pos_of(p, x, y, pre);
    if (pre) return 0;
    n = (y < VA) ? y * HA + ((x < HA) ? x : HA) : HA * VA;
    return (n > HA * VA - 1) ? HA * VA - 1 : n;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(negedge clk_sys) begin
    if (mon_on) begin
      if (ce_prev) begin
        if (sync_missed) smiss_q.push_back(steps);
        if (vbl_prev && !vbl) vfall_q.push_back(steps);
        if (!de_prev && de) begin
          derise_q.push_back(steps);
          hs_at_de.push_back(hs_cnt);
          rgb_at_de.push_back(int'({vga_r, vga_g, vga_b}));
        end
        if (hs) hs_cnt++;
        vbl_prev = vbl;
        de_prev  = de;
        if (pix_chk && steps >= 1) begin
          logic de_e;
          logic [23:0] rgb_e;
          pos_of(steps - 1, px, py, ppre);
          de_e  = (px < HA) && (py < VA);
          rgb_e = de_e ? rgb_of(word_of(py * HA + px)) : 24'd0;
          chk("pixel", {3'b0, hs, vs, hbl, vbl, de, vga_r, vga_g, vga_b},
              {3'b0, (px >= HSS && px < HSE), (py >= VSS && py < VSE),
               (px >= HA), (py >= VA), de_e, rgb_e});
          chk("fb_addr", 32'(fb_addr), exp_addr(steps + 1));
          chk("locked_free", 32'(locked), 32'd0);
        end
        steps++;
      end
      if (pix_chk) begin
        chk("ce_pix", 32'(ce_pix), 32'((cyc % 4) == 0));
        chk("sync_missed_free", 32'(sync_missed), 32'd0);
      end
      ce_prev = ce_pix;
      cyc++;
    end
  end

  task automatic do_reset(input bit fr);
    mon_on = 0; pix_chk = 0;
    reset = 1'b1; freerun = fr; fb_frame_done = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("reset_outputs", {ce_pix, hs, vs, hbl, vbl, de, sync_missed, locked, vga_r, vga_g, vga_b}, 32'd0);
    chk("reset_fb_addr", 32'(fb_addr), 32'd0);
    reset = 1'b0;
    #1;
    vfall_q.delete(); smiss_q.delete(); derise_q.delete(); hs_at_de.delete(); rgb_at_de.delete();
    steps = 0; cyc = 0; hs_cnt = 0; ce_prev = 0; vbl_prev = 0; de_prev = 0;
    mon_on = 1;
  endtask

  task automatic wait_steps(input int n);
    int guard = 0;
    while (steps < n && guard < 5000) begin
      @(negedge clk_sys); #1; guard++;
    end
    if (steps < n) chk("wait_steps", steps, n);
  endtask

  task automatic wait_ce_at(input int n);
    int guard = 0;
    while (!(steps == n && ce_pix) && guard < 5000) begin
      @(negedge clk_sys); #1; guard++;
    end
    if (guard >= 5000) chk("wait_ce_timeout", guard, 0);
  endtask

  task automatic pulse_done();
    fb_frame_done = 1'b1;
    @(negedge clk_sys); #1;
    fb_frame_done = 1'b0;
  endtask

  initial begin
    // Freerun: per-pixel raster, addresses and ce cadence; 12-line frames.
    do_reset(1'b1);
    pix_chk = 1;
    wait_steps(300);
    pix_chk = 0;
    chk("free_vfall_n", vfall_q.size(), 2);
    chk("free_vfall0", qget(vfall_q, 0), 13);
    chk("free_vfall1", qget(vfall_q, 1), 157);
    chk("free_smiss_n", smiss_q.size(), 0);

    // Sync in blank line, then mid-frame sync: 12-line frame, then 16-line timeout.
    do_reset(1'b0);
    wait_steps(3);   pulse_done();
    wait_steps(75);  pulse_done();
    wait_steps(200); chk("sync_locked", 32'(locked), 32'd1);
    wait_steps(360); chk("sync_unlocked", 32'(locked), 32'd0);
    chk("sync_vfall_n", vfall_q.size(), 3);
    chk("sync_vfall0", qget(vfall_q, 0), 13);
    chk("sync_vfall1", qget(vfall_q, 1), 157);
    chk("sync_vfall2", qget(vfall_q, 2), 349);
    chk("sync_smiss_n", smiss_q.size(), 1);
    chk("sync_smiss0", qget(smiss_q, 0), 347);

    // Pulse coinciding with the restart clear keeps the next frame at 12 lines.
    do_reset(1'b0);
    wait_steps(3); pulse_done();
    wait_ce_at(11); pulse_done();
    wait_steps(200); chk("keep_locked", 32'(locked), 32'd1);
    wait_steps(360);
    chk("keep_vfall1", qget(vfall_q, 1), 157);
    chk("keep_vfall2", qget(vfall_q, 2), 349);
    chk("keep_smiss0", qget(smiss_q, 0), 347);

    // No sync at all: blank until line V_MAX-1 each time.
    do_reset(1'b0);
    wait_steps(320);
    chk("to_smiss_n", smiss_q.size(), 2);
    chk("to_smiss0", qget(smiss_q, 0), 119);
    chk("to_smiss1", qget(smiss_q, 1), 311);
    chk("to_vfall0", qget(vfall_q, 0), 121);
    chk("to_vfall1", qget(vfall_q, 1), 313);
    chk("to_locked", 32'(locked), 32'd0);

    // Reset mid-read at x=4,y=3, then a synced restart.
    do_reset(1'b1);
    pix_chk = 1;
    wait_ce_at(52);
    pix_chk = 0;
    chk("mid_fb_addr", 32'(fb_addr), 32'd28);
    reset = 1'b1;
    @(negedge clk_sys); #1;
    chk("mid_reset_outputs", {ce_pix, hs, vs, hbl, vbl, de, sync_missed, locked, vga_r, vga_g, vga_b}, 32'd0);
    chk("mid_reset_fb_addr", 32'(fb_addr), 32'd0);
    do_reset(1'b0);
    wait_steps(3); pulse_done();
    wait_steps(20);
    chk("post_vfall0", qget(vfall_q, 0), 13);
    chk("post_de_first", qget(derise_q, 0), 13);
    chk("post_hs_before_de", qget(hs_at_de, 0), 2);
    chk("post_rgb_first", qget(rgb_at_de, 0), int'(rgb_of(word_of(0))));
    chk("post_locked", 32'(locked), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
